// File: rtl/if_sequencer.sv
// rtl/if_sequencer.sv - instruction-fetch control sequencer (stall, miss refill, syscall drain, redirect)
//
// Decides each cycle whether IF advances, stalls, redirects or bubbles.
// Ports:
//   CLK, RESET                 clock (rising edge), asynchronous active-low reset
//   Fetch_Addr, IC_Hit         current fetch address and its I-cache hit flag
//   Hazard_Stall               ID hazard, freezes IF
//   Branch_Taken/Target        taken branch/jump resolved in ID
//   Syscall_Decoded            syscall in ID (only honoured in RUN)
//   Refill_Done                refill engine line-written pulse
//   Refill_Req, Refill_Addr    registered refill request and line-aligned address
//   STALL, miss                IF freeze and refill-in-progress flags
//   SYS, sys_count             syscall drain window and its counter
//   Request_Alt_PC, Alt_PC     redirect strobe and target
//   Request_Alt_PC1            Request_Alt_PC delayed one cycle
//   Syscall_Done               one-cycle pulse in the first RUN cycle after a drain
module if_sequencer #(
  parameter int LINE_LOG2 = 4,
  parameter int SYS_DRAIN = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Fetch_Addr,
  input  logic        IC_Hit,
  input  logic        Hazard_Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Syscall_Decoded,
  input  logic        Refill_Done,
  output logic        Refill_Req,
  output logic [31:0] Refill_Addr,
  output logic        STALL,
  output logic        miss,
  output logic        SYS,
  output logic [2:0]  sys_count,
  output logic        Request_Alt_PC,
  output logic [31:0] Alt_PC,
  output logic        Request_Alt_PC1,
  output logic        Syscall_Done
);

  localparam logic [2:0]  DRAIN_LAST = 3'(SYS_DRAIN);
  // Masking (rather than slicing) keeps every Fetch_Addr bit in use.
  localparam logic [31:0] LINE_MASK  = ~((32'd1 << LINE_LOG2) - 32'd1);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_MISS_WAIT = 2'd1,
    S_MISS_FILL = 2'd2,
    S_SYS_DRAIN = 2'd3
  } state_t;

  state_t      state, next_state;
  logic        pend_valid;
  logic [31:0] pend_target;

  always_comb begin
    next_state     = state;
    STALL          = 1'b1;
    Request_Alt_PC = 1'b0;
    Alt_PC         = pend_target;
    case (state)
      S_RUN: begin
        STALL          = Hazard_Stall | ~IC_Hit;
        // A branch resolved this cycle wins over an older pending target.
        Request_Alt_PC = Branch_Taken | pend_valid;
        Alt_PC         = Branch_Taken ? Branch_Target : pend_target;
        if (!IC_Hit)
          next_state = S_MISS_WAIT;
        else if (Syscall_Decoded)
          next_state = S_SYS_DRAIN;
      end
      S_MISS_WAIT: if (Refill_Done) next_state = S_MISS_FILL;
      S_MISS_FILL: next_state = S_RUN;
      S_SYS_DRAIN: if (sys_count == DRAIN_LAST) next_state = S_RUN;
      default:     next_state = S_RUN;
    endcase
  end

  assign miss = (state == S_MISS_WAIT) || (state == S_MISS_FILL);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state           <= S_RUN;
      Refill_Req      <= 1'b0;
      Refill_Addr     <= 32'd0;
      SYS             <= 1'b0;
      sys_count       <= 3'd0;
      Syscall_Done    <= 1'b0;
      Request_Alt_PC1 <= 1'b0;
      pend_valid      <= 1'b0;
      pend_target     <= 32'd0;
    end else begin
      state           <= next_state;
      Request_Alt_PC1 <= Request_Alt_PC;
      Syscall_Done    <= (state == S_SYS_DRAIN) && (sys_count == DRAIN_LAST);

      if (state == S_RUN && !IC_Hit) begin
        Refill_Req  <= 1'b1;
        Refill_Addr <= Fetch_Addr & LINE_MASK;
      end else if (state == S_MISS_WAIT && Refill_Done) begin
        Refill_Req  <= 1'b0;
      end

      if (state == S_RUN && IC_Hit && Syscall_Decoded) begin
        SYS       <= 1'b1;
        sys_count <= 3'd0;
      end else if (state == S_SYS_DRAIN) begin
        if (sys_count == DRAIN_LAST) begin
          SYS       <= 1'b0;
          sys_count <= 3'd0;
        end else begin
          sys_count <= sys_count + 3'd1;
        end
      end

      // Redirects seen outside RUN are parked; the latest target wins and
      // the first RUN cycle consumes it.
      if (state != S_RUN && Branch_Taken) begin
        pend_valid  <= 1'b1;
        pend_target <= Branch_Target;
      end else if (state == S_RUN) begin
        pend_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_sequencer.sv
// tb/tb_if_sequencer.sv - self-checking bench for if_sequencer
module tb_if_sequencer;

  logic        CLK, RESET;
  logic [31:0] Fetch_Addr, Branch_Target;
  logic        IC_Hit, Hazard_Stall, Branch_Taken, Syscall_Decoded, Refill_Done;
  logic        Refill_Req, STALL, miss, SYS, Request_Alt_PC, Request_Alt_PC1, Syscall_Done;
  logic [31:0] Refill_Addr, Alt_PC;
  logic [2:0]  sys_count;

  if_sequencer #(.LINE_LOG2(4), .SYS_DRAIN(4)) dut (
    .CLK(CLK), .RESET(RESET), .Fetch_Addr(Fetch_Addr), .IC_Hit(IC_Hit),
    .Hazard_Stall(Hazard_Stall), .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Syscall_Decoded(Syscall_Decoded), .Refill_Done(Refill_Done),
    .Refill_Req(Refill_Req), .Refill_Addr(Refill_Addr), .STALL(STALL), .miss(miss),
    .SYS(SYS), .sys_count(sys_count), .Request_Alt_PC(Request_Alt_PC), .Alt_PC(Alt_PC),
    .Request_Alt_PC1(Request_Alt_PC1), .Syscall_Done(Syscall_Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall, miss, req, sys, areq, areq1, done;
    logic [31:0] addr, apc;
    logic [2:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        e_stall, e_miss, e_req, e_sys, e_areq, e_areq1, e_done;
  logic [31:0] e_addr, e_apc;
  logic [2:0]  e_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic in_idle();
    IC_Hit = 1'b1; Hazard_Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'd0;
    Syscall_Decoded = 1'b0; Refill_Done = 1'b0; Fetch_Addr = 32'h0000_1000;
  endtask

  // Quiet RUN expectations; Refill_Addr stays whatever was last latched.
  task automatic exp_idle();
    e_stall = 0; e_miss = 0; e_req = 0; e_sys = 0; e_cnt = 0;
    e_areq = 0; e_areq1 = 0; e_done = 0; e_apc = 32'd0;
  endtask

  // One cycle: inputs and e_* were set by the caller after the last rising edge.
  task automatic tick(input string tag);
    exp_t e, g;
    e.stall = e_stall; e.miss = e_miss; e.req = e_req; e.sys = e_sys; e.cnt = e_cnt;
    e.areq = e_areq; e.areq1 = e_areq1; e.done = e_done; e.addr = e_addr; e.apc = e_apc;
    sb.push_back(e);
    @(negedge CLK);
    g = sb.pop_front();
    check({tag, ".STALL"}, 32'(STALL), 32'(g.stall));
    check({tag, ".miss"}, 32'(miss), 32'(g.miss));
    check({tag, ".Refill_Req"}, 32'(Refill_Req), 32'(g.req));
    check({tag, ".Refill_Addr"}, Refill_Addr, g.addr);
    check({tag, ".SYS"}, 32'(SYS), 32'(g.sys));
    check({tag, ".sys_count"}, 32'(sys_count), 32'(g.cnt));
    check({tag, ".Request_Alt_PC"}, 32'(Request_Alt_PC), 32'(g.areq));
    if (g.areq) check({tag, ".Alt_PC"}, Alt_PC, g.apc);
    check({tag, ".Request_Alt_PC1"}, 32'(Request_Alt_PC1), 32'(g.areq1));
    check({tag, ".Syscall_Done"}, 32'(Syscall_Done), 32'(g.done));
    @(posedge CLK); #1;
    in_idle();
    exp_idle();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0; in_idle(); exp_idle(); e_addr = 32'd0;
    #2;
    check("rst.Refill_Req", 32'(Refill_Req), 32'd0);
    check("rst.Refill_Addr", Refill_Addr, 32'd0);
    check("rst.SYS", 32'(SYS), 32'd0);
    check("rst.sys_count", 32'(sys_count), 32'd0);
    check("rst.Alt_PC", Alt_PC, 32'd0);
    check("rst.STALL", 32'(STALL), 32'd0);
    check("rst.miss", 32'(miss), 32'd0);
    @(posedge CLK); #1; RESET = 1'b1;
    tick("idle0");
    tick("idle1");

    // Miss at 0xBFC0_0014, Refill_Done five cycles after the miss.
    IC_Hit = 0; Fetch_Addr = 32'hBFC0_0014; e_stall = 1; tick("miss.n");
    for (int i = 1; i <= 5; i++) begin
      e_stall = 1; e_miss = 1; e_req = 1; e_addr = 32'hBFC0_0010;
      if (i == 5) Refill_Done = 1;
      if (i == 2) IC_Hit = 0;
      tick($sformatf("miss.w%0d", i));
    end
    e_stall = 1; e_miss = 1; tick("miss.fill");
    tick("miss.run");
    Refill_Done = 1; tick("miss.done_in_run");

    // Syscall drain: SYS for cnt 0..4, Syscall_Done in the first RUN cycle.
    Syscall_Decoded = 1; tick("sys.dec");
    for (int i = 0; i <= 4; i++) begin
      e_stall = 1; e_sys = 1; e_cnt = 3'(i);
      if (i == 0) Syscall_Decoded = 1;
      if (i == 2) begin IC_Hit = 0; Refill_Done = 1; end
      tick($sformatf("sys.c%0d", i));
    end
    e_done = 1; tick("sys.done");
    tick("sys.after");

    // Branch during MISS_WAIT waits for RUN; minimum 3-cycle miss stall.
    IC_Hit = 0; Fetch_Addr = 32'h0000_1238; e_stall = 1; tick("br.miss");
    e_addr = 32'h0000_1230;
    Branch_Taken = 1; Branch_Target = 32'h0040_0100; Refill_Done = 1;
    e_stall = 1; e_miss = 1; e_req = 1; tick("br.wait");
    e_stall = 1; e_miss = 1; tick("br.fill");
    e_areq = 1; e_apc = 32'h0040_0100; tick("br.issue");
    e_areq1 = 1; tick("br.delay");
    tick("br.quiet");

    // Pending target overridden by a branch in the first RUN cycle.
    IC_Hit = 0; Fetch_Addr = 32'h0000_2004; e_stall = 1; tick("ov.miss");
    e_addr = 32'h0000_2000;
    Branch_Taken = 1; Branch_Target = 32'h1111_1110;
    e_stall = 1; e_miss = 1; e_req = 1; tick("ov.wait1");
    Branch_Taken = 1; Branch_Target = 32'h3333_3330; Refill_Done = 1;
    e_stall = 1; e_miss = 1; e_req = 1; tick("ov.wait2");
    e_stall = 1; e_miss = 1; tick("ov.fill");
    Branch_Taken = 1; Branch_Target = 32'h2222_2220;
    e_areq = 1; e_apc = 32'h2222_2220; tick("ov.issue");
    e_areq1 = 1; tick("ov.cleared");

    // Hazard for three cycles in RUN.
    for (int i = 0; i < 3; i++) begin
      Hazard_Stall = 1; e_stall = 1; tick($sformatf("hz%0d", i));
    end
    tick("hz.end");

    // Miss + syscall + branch together: redirect issues, miss taken, syscall dropped.
    IC_Hit = 0; Syscall_Decoded = 1; Branch_Taken = 1; Branch_Target = 32'h0000_0ABC;
    Fetch_Addr = 32'h0000_0ABC; e_stall = 1; e_areq = 1; e_apc = 32'h0000_0ABC; tick("mix.n");
    e_addr = 32'h0000_0AB0;
    Refill_Done = 1; e_stall = 1; e_miss = 1; e_req = 1; e_areq1 = 1; tick("mix.wait");
    e_stall = 1; e_miss = 1; tick("mix.fill");
    tick("mix.run");

    // Asynchronous reset while a refill is outstanding.
    IC_Hit = 0; Fetch_Addr = 32'hBFC0_0014; e_stall = 1; tick("ar.miss");
    #2; RESET = 1'b0; #1;
    check("ar.Refill_Req", 32'(Refill_Req), 32'd0);
    check("ar.miss", 32'(miss), 32'd0);
    check("ar.Refill_Addr", Refill_Addr, 32'd0);
    @(posedge CLK); #1; RESET = 1'b1;
    e_addr = 32'd0;
    tick("ar.run0");
    Syscall_Decoded = 1; tick("ar.sys");
    e_stall = 1; e_sys = 1; tick("ar.sys0");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
